// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit.
// One iteration per clock; results are registered and held until the next completion.
module mul_div_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dbz_q, dbz_d;

    // One iteration of each algorithm; hi/lo hold the working accumulator.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (op_q) begin
            // Borrow in div_diff[WIDTH] means the trial subtraction is restored.
            iter_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            iter_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dz_d     = dz_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    op_d    = op;
                    dbz_d   = 1'b0;
                    dz_d    = op && (operand_b == '0);
                    hi_d    = '0;
                    // Multiply keeps the multiplier in lo and the multiplicand in b.
                    lo_d    = op ? operand_a : operand_b;
                    b_d     = op ? operand_b : operand_a;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (dz_q) begin
                    state_d  = S_DONE;
                    res_lo_d = {WIDTH{1'b1}};
                    res_hi_d = lo_q;
                    dbz_d    = 1'b1;
                end else begin
                    hi_d  = iter_hi;
                    lo_d  = iter_lo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = S_DONE;
                        res_lo_d = iter_lo;
                        res_hi_d = iter_hi;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            dz_q     <= 1'b0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dz_q     <= dz_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Table-driven bench for mul_div_unit, plus hand sequences for ignored start,
// back-to-back start and mid-operation reset.
module tb_mul_div_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       busy;
    logic       done;
    logic [7:0] result_lo;
    logic [7:0] result_hi;
    logic       div_by_zero;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_lo = 8'h00;
    logic [7:0] prev_hi = 8'h00;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    mul_div_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .div_by_zero(div_by_zero), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Wait up to 20 negedges for done; returns index of the negedge it was seen on.
    task automatic wait_done(input int first_j, input int exp_lat, output int lat);
        bit busy_ok;
        busy_ok = 1'b1;
        lat = -1;
        for (int j = first_j; j <= 20; j++) begin
            @(negedge clk);
            if (done) begin
                lat = j;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        check("busy_through_run", 16'(busy_ok), 16'd1);
        check("latency", 16'(lat), 16'(exp_lat));
        check("busy_low_at_done", 16'(busy), 16'd0);
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        @(negedge clk);
        start = 1'b1; op = v.op; operand_a = v.a; operand_b = v.b;
        @(negedge clk);
        start = 1'b0; op = 1'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
        check("busy_after_accept", 16'(busy), 16'd1);
        check("dbz_cleared_on_accept", 16'(div_by_zero), 16'd0);
        check("lo_held_in_run", 16'(result_lo), 16'(prev_lo));
        check("hi_held_in_run", 16'(result_hi), 16'(prev_hi));
        wait_done(1, v.lat, lat);
        check("result_lo", 16'(result_lo), 16'(v.lo));
        check("result_hi", 16'(result_hi), 16'(v.hi));
        check("div_by_zero", 16'(div_by_zero), 16'(v.dbz));
        prev_lo = v.lo;
        prev_hi = v.hi;
        @(negedge clk);
        check("done_one_cycle", 16'(done), 16'd0);
        check("state_idle_after", 16'(dbg_state), 16'd0);
        check("lo_held_idle", 16'(result_lo), 16'(v.lo));
        check("dbz_held_idle", 16'(div_by_zero), 16'(v.dbz));
    endtask

    initial begin
        int lat;
        int seen_done;
        vec_t v;

        vecs[0]  = '{1'b0, 8'd13,  8'd11,  8'h8F, 8'h00, 1'b0, 8};
        vecs[1]  = '{1'b0, 8'd255, 8'd255, 8'h01, 8'hFE, 1'b0, 8};
        vecs[2]  = '{1'b1, 8'd200, 8'd7,   8'h1C, 8'h04, 1'b0, 8};
        vecs[3]  = '{1'b1, 8'd5,   8'd0,   8'hFF, 8'h05, 1'b1, 1};
        vecs[4]  = '{1'b0, 8'd0,   8'd77,  8'h00, 8'h00, 1'b0, 8};
        vecs[5]  = '{1'b1, 8'd0,   8'd3,   8'h00, 8'h00, 1'b0, 8};
        vecs[6]  = '{1'b1, 8'd7,   8'd200, 8'h00, 8'h07, 1'b0, 8};
        vecs[7]  = '{1'b1, 8'd255, 8'd1,   8'hFF, 8'h00, 1'b0, 8};
        vecs[8]  = '{1'b0, 8'd128, 8'd2,   8'h00, 8'h01, 1'b0, 8};
        vecs[9]  = '{1'b1, 8'd100, 8'd10,  8'h0A, 8'h00, 1'b0, 8};
        vecs[10] = '{1'b1, 8'd255, 8'd255, 8'h01, 8'h00, 1'b0, 8};
        vecs[11] = '{1'b1, 8'd0,   8'd0,   8'hFF, 8'h00, 1'b1, 1};

        // Reset
        rst_n = 1'b0; start = 1'b0; op = 1'b0; operand_a = 8'h00; operand_b = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_lo", 16'(result_lo), 16'd0);
        check("rst_hi", 16'(result_hi), 16'd0);
        check("rst_dbz", 16'(div_by_zero), 16'd0);
        check("rst_state", 16'(dbg_state), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 16'(dbg_state), 16'd0);

        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // Start during RUN is ignored; then back-to-back start during DONE.
        @(negedge clk);
        start = 1'b1; op = 1'b0; operand_a = 8'd3; operand_b = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 1'b1; operand_a = 8'd9; operand_b = 8'd2;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", 16'(busy), 16'd1);
        wait_done(4, 8, lat);
        check("ign_lo", 16'(result_lo), 16'h0C);
        check("ign_hi", 16'(result_hi), 16'h00);
        check("ign_dbz", 16'(div_by_zero), 16'd0);
        start = 1'b1; op = 1'b0; operand_a = 8'd2; operand_b = 8'd2;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_low", 16'(done), 16'd0);
        check("b2b_busy", 16'(busy), 16'd1);
        check("b2b_lo_held", 16'(result_lo), 16'h0C);
        wait_done(1, 8, lat);
        check("b2b_lo", 16'(result_lo), 16'h04);
        check("b2b_hi", 16'(result_hi), 16'h00);
        @(negedge clk);
        check("b2b_idle", 16'(dbg_state), 16'd0);

        // Reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 1'b1; operand_a = 8'd100; operand_b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_done", 16'(done), 16'd0);
        check("mid_rst_lo", 16'(result_lo), 16'd0);
        check("mid_rst_hi", 16'(result_hi), 16'd0);
        check("mid_rst_dbz", 16'(div_by_zero), 16'd0);
        check("mid_rst_state", 16'(dbg_state), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("no_done_after_rst", 16'(seen_done), 16'd0);
        check("idle_after_rst", 16'(dbg_state), 16'd0);
        prev_lo = 8'h00;
        prev_hi = 8'h00;
        v = '{1'b0, 8'd6, 8'd7, 8'h2A, 8'h00, 1'b0, 8};
        run_op(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
